// File: rtl/fir_decimator_buffer.sv
// Decimating output buffer for the FIR filters: keeps every DECIM-th valid sample
// and queues kept samples in a DEPTH-entry show-ahead FIFO with overflow accounting.
module fir_decimator_buffer #(
  parameter int WIDTH = 16,
  parameter int DECIM = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic signed [WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  input  logic                      clear_ovf,
  output logic [CNT_W-1:0]          drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [LW-1:0]    FULL    = LW'(DEPTH);
  localparam logic [PW-1:0]    PH_LAST = PW'(DECIM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]           phase;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           rd_ptr_nxt;
  logic [LW-1:0]           level_nxt;
  logic                    keep;
  logic                    pop;
  logic                    push;
  logic                    drop;
  logic                    full;
  logic signed [WIDTH-1:0] head_nxt;

  always_comb begin
    full       = (level == FULL);
    keep       = in_valid && (phase == '0);
    pop        = out_valid && out_ready;
    push       = keep && (!full || pop);
    drop       = keep && full && !pop;
    level_nxt  = level + LW'(push) - LW'(pop);
    rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
    // When the incoming sample becomes the head it is not in memory yet, so bypass it.
    if (level_nxt == '0)
      head_nxt = out_data;
    else if (push && (level == LW'(pop)))
      head_nxt = in_data;
    else
      head_nxt = mem[rd_ptr_nxt];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (in_valid)
        phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_ptr_nxt;
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      out_data  <= head_nxt;
      // A drop in the same cycle as clear_ovf restarts the count at one.
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= clear_ovf ? CNT_W'(1)
                    : (drop_count == CNT_MAX) ? drop_count : drop_count + CNT_W'(1);
      end else if (clear_ovf) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

  // NOTE: storage is deliberately not reset; level/pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (reset && push)
      mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_fir_decimator_buffer.sv
// Scoreboard bench for fir_decimator_buffer: two instances (DECIM=4/CNT_W=8 and
// DECIM=1/CNT_W=2) driven by directed and random stimulus against a queue-based model.
module tb_fir_decimator_buffer;

  localparam int W     = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  logic iv [2];
  logic rdy [2];
  logic clr [2];
  logic signed [W-1:0] id [2];

  logic                ov0, ov1, of0, of1;
  logic signed [W-1:0] od0, od1;
  logic [3:0]          lv0, lv1;
  logic [7:0]          dc0;
  logic [1:0]          dc1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model state (written only by the model process)
  int m_level [2];
  int m_vcnt  [2];
  int m_drops [2];
  bit m_ovf   [2];
  bit mp, mk;
  // Last head value shown (owned by the monitor)
  logic signed [W-1:0] m_last [2] = '{16'sd0, 16'sd0};
  logic signed [W-1:0] q0 [$];
  logic signed [W-1:0] q1 [$];

  always #5 clk = ~clk;

  fir_decimator_buffer #(.WIDTH(W), .DECIM(4), .DEPTH(DEPTH), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_data(id[0]),
    .out_valid(ov0), .out_ready(rdy[0]), .out_data(od0), .level(lv0),
    .overflow(of0), .clear_ovf(clr[0]), .drop_count(dc0)
  );

  fir_decimator_buffer #(.WIDTH(W), .DECIM(1), .DEPTH(DEPTH), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_data(id[1]),
    .out_valid(ov1), .out_ready(rdy[1]), .out_data(od1), .level(lv1),
    .overflow(of1), .clear_ovf(clr[1]), .drop_count(dc1)
  );

  function automatic int dec_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int cmax_of(input int i);
    return (i == 0) ? 255 : 3;
  endfunction

  function automatic int q_size(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic signed [W-1:0] q_front(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic q_push(input int i, input logic signed [W-1:0] v);
    if (i == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic q_pop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic q_clear(input int i);
    if (i == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: keep the n-th valid sample when n % DECIM == 0, queue up to DEPTH.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_level[i] = 0;
        m_vcnt[i]  = 0;
        m_ovf[i]   = 1'b0;
        m_drops[i] = 0;
      end else begin
        mp = (m_level[i] > 0) && rdy[i];
        mk = iv[i] && (m_vcnt[i] % dec_of(i) == 0);
        if (iv[i]) m_vcnt[i]++;
        if (clr[i]) begin
          m_ovf[i]   = 1'b0;
          m_drops[i] = 0;
        end
        if (mk) begin
          if (m_level[i] < DEPTH || mp) begin
            q_push(i, id[i]);
            m_level[i]++;
          end else begin
            m_ovf[i] = 1'b1;
            if (m_drops[i] < cmax_of(i)) m_drops[i]++;
          end
        end
        if (mp) m_level[i]--;
      end
    end
  end

  task automatic mon(input int i, input logic v, input logic signed [W-1:0] d,
                     input logic [3:0] l, input logic o, input int c);
    logic signed [W-1:0] e;
    check($sformatf("out_valid[%0d]", i), int'(v), int'(m_level[i] != 0));
    check($sformatf("level[%0d]", i), int'(l), m_level[i]);
    check($sformatf("overflow[%0d]", i), int'(o), int'(m_ovf[i]));
    check($sformatf("drop_count[%0d]", i), c, m_drops[i]);
    if (v === 1'b1) begin
      if (q_size(i) == 0) begin
        checks++;
        errors++;
        $display("FAIL out_data[%0d]: got %0d with no sample expected (t=%0t)", i, d, $time);
      end else begin
        e = q_front(i);
        check($sformatf("out_data[%0d]", i), int'(d), int'(e));
        m_last[i] = e;
        if (rdy[i]) q_pop(i);
      end
    end else begin
      check($sformatf("held_data[%0d]", i), int'(d), int'(m_last[i]));
    end
    if (!reset) begin
      q_clear(i);
      m_last[i] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, ov0, od0, lv0, of0, int'(dc0));
      mon(1, ov1, od1, lv1, of1, int'(dc1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic feed0(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      iv[0] = 1'b1;
      id[0] = 16'(first + k);
      step();
    end
    iv[0] = 1'b0;
  endtask

  task automatic drain(input int n);
    iv[0] = 1'b0; iv[1] = 1'b0;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; rdy[i] = 1'b0; clr[i] = 1'b0; id[i] = '0;
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step();
    reset = 1'b1;
    check("reset_level", int'(lv0), 0);
    check("reset_data", int'(od0), 0);

    // Continuous stream, always ready: 0,4,8,... one per 4 clocks
    rdy[0] = 1'b1;
    feed0(0, 60);
    drain(4);

    // Stall: 40 samples, 8 held, 2 dropped, then drain
    do_reset();
    rdy[0] = 1'b0;
    feed0(0, 40);
    check("stall_level", int'(lv0), 8);
    check("stall_overflow", int'(of0), 1);
    check("stall_drops", int'(dc0), 2);
    drain(12);
    check("stall_drained", int'(lv0), 0);

    // Full FIFO with a pop on the same cycle a kept sample arrives
    do_reset();
    rdy[0] = 1'b0;
    feed0(0, 32);
    rdy[0] = 1'b1; iv[0] = 1'b1; id[0] = 16'sd32;
    step();
    rdy[0] = 1'b0; iv[0] = 1'b0;
    check("full_pop_level", int'(lv0), 8);
    check("full_pop_drops", int'(dc0), 0);
    drain(12);

    // Mid-stream reset with level 5; phase restarts
    do_reset();
    rdy[0] = 1'b0;
    feed0(0, 20);
    check("pre_reset_level", int'(lv0), 5);
    reset = 1'b0; iv[0] = 1'b1; id[0] = 16'sd100;
    step();
    reset = 1'b1;
    check("mid_reset_valid", int'(ov0), 0);
    check("mid_reset_level", int'(lv0), 0);
    check("mid_reset_data", int'(od0), 0);
    id[0] = 16'sd200;
    step();
    iv[0] = 1'b0;
    check("post_reset_kept", int'(od0), 200);
    drain(4);

    // Overflow clear, then clear coinciding with a drop
    do_reset();
    rdy[0] = 1'b0;
    feed0(0, 44);
    check("ovf_drops3", int'(dc0), 3);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    check("clear_ovf", int'(of0), 0);
    check("clear_drops", int'(dc0), 0);
    clr[0] = 1'b1; iv[0] = 1'b1; id[0] = 16'sd44;
    step();
    clr[0] = 1'b0; iv[0] = 1'b0;
    check("clear_vs_drop_ovf", int'(of0), 1);
    check("clear_vs_drop_cnt", int'(dc0), 1);
    drain(12);

    // DECIM=1 instance: extremes with gaps, then drop_count saturation
    rdy[1] = 1'b1;
    iv[1] = 1'b1; id[1] = -16'sd32768; step();
    iv[1] = 1'b0; step();
    iv[1] = 1'b1; id[1] = 16'sd32767;  step();
    iv[1] = 1'b0; step();
    iv[1] = 1'b1; id[1] = -16'sd1;     step();
    iv[1] = 1'b0; step();
    step();
    rdy[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      iv[1] = 1'b1; id[1] = 16'(k * 7 - 40);
      step();
    end
    iv[1] = 1'b0;
    check("sat_drops", int'(dc1), 3);
    drain(12);

    // Randomised traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        iv[i]  = ($urandom_range(0, 99) < 70);
        id[i]  = 16'($urandom);
        rdy[i] = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 80 : 20));
        clr[i] = ($urandom_range(0, 99) < 2);
      end
      reset = ($urandom_range(0, 999) >= 5);
      step();
    end
    reset = 1'b1;
    clr[0] = 1'b0; clr[1] = 1'b0;
    drain(20);
    check("final_empty0", q_size(0), 0);
    check("final_empty1", q_size(1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
